hidden_layer_accumulator: RTL

- Consumer stage directly downstream of the input index queue.
- After the image is loaded, it pulls active-pixel indices from the queue one at a time through the dequeue handshake.
- For each index it reads one signed weight per hidden node from an external synchronous weight ROM and accumulates it into that node's saturating accumulator.
- When the queue empties it signals done; the hidden-layer activation stage then reads the sums out.

---
 rtl/hidden_layer_accumulator.sv | 133 +++++++++++++
 1 files changed

// File: rtl/hidden_layer_accumulator.sv
// Hidden-layer accumulator: drains active-pixel indices from the input queue and
// accumulates one signed ROM weight per hidden node into saturating sums.
module hidden_layer_accumulator #(
  parameter int INPUT_NODES  = 784,
  parameter int HIDDEN_NODES = 16,
  parameter int NODE_W       = 4,
  parameter int WEIGHT_W     = 8,
  parameter int ACC_W        = 16,
  parameter int ADDR_W       = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [9:0]          index_in,
  input  logic                queue_empty,
  output logic                dequeue,
  output logic [ADDR_W-1:0]   weight_addr,
  input  logic [WEIGHT_W-1:0] weight_data,
  output logic                busy,
  output logic                done,
  input  logic [NODE_W-1:0]   rd_node,
  output logic [ACC_W-1:0]    rd_sum
);

  localparam int CNT_W = $clog2(INPUT_NODES + 1);
  localparam int K_W   = NODE_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_CHECK, S_REQ, S_HOLD, S_LATCH, S_ACC, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [9:0]         idx_q, idx_d;
  logic [K_W-1:0]     node_q, node_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ACC_W-1:0]   acc_q [HIDDEN_NODES];
  logic [ACC_W-1:0]   acc_d [HIDDEN_NODES];

  logic [NODE_W-1:0]  acc_sel;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   sat;

  // ROM data arrives one cycle after its address, so ACC cycle k adds into node k-1.
  always_comb begin
    acc_sel = NODE_W'(node_q - K_W'(1));
    sum     = {acc_q[acc_sel][ACC_W-1], acc_q[acc_sel]}
            + {{(ACC_W + 1 - WEIGHT_W){weight_data[WEIGHT_W-1]}}, weight_data};
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      sat = {sum[ACC_W], {(ACC_W - 1){~sum[ACC_W]}}};
    end else begin
      sat = sum[ACC_W-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    node_d      = node_q;
    addr_d      = addr_q;
    acc_d       = acc_q;
    dequeue     = 1'b0;
    done        = 1'b0;
    busy        = (state_q != S_IDLE);
    weight_addr = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        acc_d   = '{default: '0};
        cnt_d   = '0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (queue_empty || cnt_q == CNT_W'(INPUT_NODES)) state_d = S_DONE;
        else                                             state_d = S_REQ;
      end
      S_REQ: begin
        dequeue = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_LATCH;
      end
      S_LATCH: begin
        idx_d   = index_in;
        node_d  = '0;
        state_d = S_ACC;
      end
      S_ACC: begin
        if (node_q < K_W'(HIDDEN_NODES)) begin
          weight_addr = ADDR_W'(idx_q) * ADDR_W'(HIDDEN_NODES) + ADDR_W'(node_q);
          addr_d      = weight_addr;
        end
        if (node_q != '0) acc_d[acc_sel] = sat;
        if (node_q == K_W'(HIDDEN_NODES)) state_d = S_CHECK;
        else                              node_d  = node_q + K_W'(1);
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      node_q  <= '0;
      addr_q  <= '0;
      acc_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      node_q  <= node_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    rd_sum = '0;
    if (int'(rd_node) < HIDDEN_NODES) rd_sum = acc_q[rd_node];
  end

endmodule
